// File: rtl/dpc_pkg.sv
// dpc_pkg: shared latency, window-geometry helpers and pixel-select macro for dpc_win
`ifndef DPC_PKG_SV
`define DPC_PKG_SV

`define DPC_PIX(bus, c, r, rows, dw) bus[((c)*(rows)+(r))*(dw) +: (dw)]

package dpc_pkg;

    localparam int LAT = 3;

    function automatic int ctr_col(input int cols);
        return cols / 2;
    endfunction

    function automatic int ctr_row(input int rows);
        return rows / 2;
    endfunction

    // Centre is never a neighbour; RAW_MODE keeps only same-Bayer-colour taps (even offsets)
    function automatic bit is_nbr(input int c, input int r, input int cols, input int rows, input int raw);
        int dc;
        int dr;
        dc = c - ctr_col(cols);
        dr = r - ctr_row(rows);
        return !(dc == 0 && dr == 0) && (raw == 0 || (dc % 2 == 0 && dr % 2 == 0));
    endfunction

    // Packed slot of a neighbour = number of neighbours preceding it in window order
    function automatic int nbr_idx(input int c, input int r, input int cols, input int rows, input int raw);
        int n;
        n = 0;
        for (int i = 0; i < c * rows + r; i++)
            if (is_nbr(i / rows, i % rows, cols, rows, raw))
                n++;
        return n;
    endfunction

endpackage

`endif

// File: rtl/dpc_minmax.sv
// dpc_minmax: combinational min/max over N packed DW-bit unsigned values
module dpc_minmax #(
    parameter int N  = 24,
    parameter int DW = 8
) (
    input  logic [N*DW-1:0] d,
    output logic [DW-1:0]   mn,
    output logic [DW-1:0]   mx
);

    // Running min/max reduction across all inputs
    always_comb begin
        mn = d[DW-1:0];
        mx = d[DW-1:0];
        for (int i = 1; i < N; i++) begin
            mn = d[i*DW +: DW] < mn ? d[i*DW +: DW] : mn;
            mx = d[i*DW +: DW] > mx ? d[i*DW +: DW] : mx;
        end
    end

endmodule

// File: rtl/dpc_win.sv
// dpc_win: 3-stage defect-pixel correction of the window centre; DPC_STAT_EN adds a per-frame defect count
module dpc_win
    import dpc_pkg::*;
#(
    parameter int DBUF_DW   = 8,
    parameter int KRNV_SZ   = 5,
    parameter int ODATA_RNG = 5,
    parameter int RAW_MODE  = 0,
    parameter int THR_DW    = 8,
    parameter int CNT_DW    = 20
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [DBUF_DW*KRNV_SZ*ODATA_RNG-1:0]   i_data,
    input  logic                                   i_dvld,
    input  logic                                   i_vstr,
    input  logic                                   i_hstr,
    input  logic                                   i_hend,
    input  logic                                   i_vend,
    input  logic                                   i_en,
    input  logic [THR_DW-1:0]                      i_thr,
    output logic [DBUF_DW-1:0]                     o_data,
    output logic                                   o_dvld,
    output logic                                   o_vstr,
    output logic                                   o_hstr,
    output logic                                   o_hend,
    output logic                                   o_vend,
    output logic [CNT_DW-1:0]                      o_dpc_cnt
);

    localparam int NB = nbr_idx(ODATA_RNG, 0, ODATA_RNG, KRNV_SZ, RAW_MODE);
    localparam int CC = ctr_col(ODATA_RNG);
    localparam int CR = ctr_row(KRNV_SZ);
    localparam int CW = DBUF_DW + THR_DW + 1;

    logic [DBUF_DW*KRNV_SZ*ODATA_RNG-1:0] s1_data;
    logic                                 s1_en;
    logic [THR_DW-1:0]                    s1_thr;
    logic [4:0]                           sync_q [LAT];
    logic [NB*DBUF_DW-1:0]                nbrs;
    logic [DBUF_DW-1:0]                   nb_min, nb_max;
    logic [DBUF_DW-1:0]                   s2_ctr, s2_min, s2_max;
    logic                                 s2_en;
    logic [THR_DW-1:0]                    s2_thr;
    logic                                 hot, cold;
    logic [DBUF_DW-1:0]                   out_px;

    // Sync pipe {vend,hend,hstr,vstr,dvld}; strobes are masked when the window is not valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= i_dvld ? {i_vend, i_hend, i_hstr, i_vstr, 1'b1} : 5'b0;
            for (int i = 1; i < LAT; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {o_vend, o_hend, o_hstr, o_vstr, o_dvld} = sync_q[LAT-1];

    // S1: capture window and controls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_data <= '0;
            s1_en   <= 1'b0;
            s1_thr  <= '0;
        end else if (i_dvld) begin
            s1_data <= i_data;
            s1_en   <= i_en;
            s1_thr  <= i_thr;
        end
    end

    for (genvar c = 0; c < ODATA_RNG; c++) begin : g_col
        for (genvar r = 0; r < KRNV_SZ; r++) begin : g_row
            if (is_nbr(c, r, ODATA_RNG, KRNV_SZ, RAW_MODE)) begin : g_nb
                assign nbrs[nbr_idx(c, r, ODATA_RNG, KRNV_SZ, RAW_MODE)*DBUF_DW +: DBUF_DW] =
                    `DPC_PIX(s1_data, c, r, KRNV_SZ, DBUF_DW);
            end
        end
    end

    dpc_minmax #(.N(NB), .DW(DBUF_DW)) u_minmax (
        .d  (nbrs),
        .mn (nb_min),
        .mx (nb_max)
    );

    // S2: register centre and neighbour extremes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_ctr <= '0;
            s2_min <= '0;
            s2_max <= '0;
            s2_en  <= 1'b0;
            s2_thr <= '0;
        end else if (sync_q[0][0]) begin
            s2_ctr <= `DPC_PIX(s1_data, CC, CR, KRNV_SZ, DBUF_DW);
            s2_min <= nb_min;
            s2_max <= nb_max;
            s2_en  <= s1_en;
            s2_thr <= s1_thr;
        end
    end

    // Outlier decision in a widened domain so max+thr and ctr+thr cannot wrap
    always_comb begin
        hot    = s2_en && CW'(s2_ctr) > CW'(s2_max) + CW'(s2_thr);
        cold   = s2_en && CW'(s2_ctr) + CW'(s2_thr) < CW'(s2_min);
        out_px = hot ? s2_max : cold ? s2_min : s2_ctr;
    end

    // S3: corrected pixel, held across bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) o_data <= '0;
        else if (sync_q[1][0]) o_data <= out_px;
    end

`ifdef DPC_STAT_EN
    logic [CNT_DW-1:0] cnt, cnt_base, cnt_nxt;

    // Frame defect count restarts on vstr and saturates at all-ones
    always_comb begin
        cnt_base = sync_q[1][1] ? '0 : cnt;
        cnt_nxt  = (hot || cold) && ~&cnt_base ? cnt_base + CNT_DW'(1) : cnt_base;
    end

    // Running count, published on vend including that pixel's defect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            o_dpc_cnt <= '0;
        end else if (sync_q[1][0]) begin
            cnt <= cnt_nxt;
            if (sync_q[1][4]) o_dpc_cnt <= cnt_nxt;
        end
    end
`else
    assign o_dpc_cnt = '0;
`endif

endmodule

// File: tb/tb_dpc_win.sv
// tb_dpc_win: directed checks of dpc_win in all-neighbour and same-colour builds
module tb_dpc_win;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [199:0] win = '0;
    logic         dvld = 1'b0, vstr = 1'b0, hstr = 1'b0, hend = 1'b0, vend = 1'b0;
    logic         en = 1'b1;
    logic [7:0]   thr = '0;

    logic [7:0]   o_data, r_data;
    logic         o_dvld, o_vstr, o_hstr, o_hend, o_vend;
    logic         r_dvld, r_vstr, r_hstr, r_hend, r_vend;
    logic [19:0]  o_cnt, r_cnt;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    dpc_win dut (
        .clk(clk), .rst_n(rst_n), .i_data(win), .i_dvld(dvld),
        .i_vstr(vstr), .i_hstr(hstr), .i_hend(hend), .i_vend(vend),
        .i_en(en), .i_thr(thr), .o_data(o_data), .o_dvld(o_dvld),
        .o_vstr(o_vstr), .o_hstr(o_hstr), .o_hend(o_hend), .o_vend(o_vend),
        .o_dpc_cnt(o_cnt)
    );

    dpc_win #(.RAW_MODE(1)) dut_raw (
        .clk(clk), .rst_n(rst_n), .i_data(win), .i_dvld(dvld),
        .i_vstr(vstr), .i_hstr(hstr), .i_hend(hend), .i_vend(vend),
        .i_en(en), .i_thr(thr), .o_data(r_data), .o_dvld(r_dvld),
        .o_vstr(r_vstr), .o_hstr(r_hstr), .o_hend(r_hend), .o_vend(r_vend),
        .o_dpc_cnt(r_cnt)
    );

`ifdef DPC_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 25; i++) win[i*8 +: 8] = v;
    endtask

    task automatic setp(input int c, input int r, input logic [7:0] v);
        win[(c*5+r)*8 +: 8] = v;
    endtask

    task automatic set_str(input logic [3:0] s);
        {vend, hend, hstr, vstr} = s;
    endtask

    // One window with strobes s={vend,hend,hstr,vstr}; result expected exactly 3 edges later
    task automatic send_chk(input string tag, input logic [3:0] s, input logic [7:0] exp, input logic [7:0] exp_raw);
        dvld = 1'b1;
        set_str(s);
        @(negedge clk);
        dvld = 1'b0;
        set_str(4'b0);
        @(negedge clk);
        chk({tag, "_early_dvld"}, o_dvld, 0);
        chk({tag, "_early_str"}, {o_vend, o_hend, o_hstr, o_vstr}, 0);
        @(negedge clk);
        chk({tag, "_dvld"}, o_dvld, 1);
        chk({tag, "_data"}, o_data, exp);
        chk({tag, "_raw_data"}, r_data, exp_raw);
        chk({tag, "_str"}, {o_vend, o_hend, o_hstr, o_vstr}, s);
        @(negedge clk);
        chk({tag, "_bubble_dvld"}, o_dvld, 0);
        chk({tag, "_hold_data"}, o_data, exp);
    endtask

    // 4x4 frame of flat-100 windows; set bits of d put a hot centre (250) at that pixel
    task automatic frame(input logic [15:0] d);
        thr = 8'd10;
        for (int i = 0; i < 16; i++) begin
            fill(8'd100);
            setp(2, 2, d[i] ? 8'd250 : 8'd100);
            dvld = 1'b1;
            set_str({i == 15, i % 4 == 3, i % 4 == 0, i == 0});
            @(negedge clk);
        end
        dvld = 1'b0;
        set_str(4'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_dvld", o_dvld, 0);
        chk("rst_data", o_data, 0);
        chk("rst_str", {o_vend, o_hend, o_hstr, o_vstr}, 0);
        chk("rst_cnt", o_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        fill(8'd100); thr = 8'd10;
        send_chk("flat", 4'b0000, 8'd100, 8'd100);

        fill(8'd110); setp(0, 0, 8'd100); setp(4, 4, 8'd120); setp(2, 2, 8'd250); thr = 8'd20;
        send_chk("hot", 4'b0101, 8'd120, 8'd120);

        fill(8'd70); setp(0, 1, 8'd60); setp(4, 3, 8'd80); setp(2, 2, 8'd5);
        send_chk("cold", 4'b1010, 8'd60, 8'd70);

        fill(8'd255);
        for (int c = 0; c < 5; c += 2)
            for (int r = 0; r < 5; r += 2) setp(c, r, 8'd100);
        setp(2, 2, 8'd200); thr = 8'd10;
        send_chk("bayer", 4'b0011, 8'd200, 8'd100);

        fill(8'd110); setp(0, 0, 8'd100); setp(4, 4, 8'd120); setp(2, 2, 8'd250); thr = 8'd20; en = 1'b0;
        send_chk("bypass", 4'b1100, 8'd250, 8'd250);
        en = 1'b1;

        fill(8'd100); setp(0, 0, 8'd90); setp(4, 4, 8'd110); setp(2, 2, 8'd110); thr = 8'd0;
        send_chk("eq_max", 4'b0000, 8'd110, 8'd110);
        setp(2, 2, 8'd90);
        send_chk("eq_min", 4'b0000, 8'd90, 8'd90);

        fill(8'd250); setp(2, 2, 8'd255); thr = 8'd255;
        send_chk("nowrap_hot", 4'b0000, 8'd255, 8'd255);
        setp(2, 2, 8'd200); thr = 8'd100;
        send_chk("nowrap_cold", 4'b0000, 8'd200, 8'd200);

        frame(16'h8021);
        chk("frame1_cnt", o_cnt, STAT ? 3 : 0);
        chk("frame1_raw_cnt", r_cnt, STAT ? 3 : 0);
        frame(16'h0000);
        chk("frame2_cnt", o_cnt, 0);
        frame(16'h0080);
        chk("frame3_cnt", o_cnt, STAT ? 1 : 0);

        fill(8'd100); thr = 8'd10; dvld = 1'b1; hstr = 1'b1;
        @(negedge clk);
        hstr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dvld = 1'b0;
        chk("midrst_dvld", o_dvld, 0);
        chk("midrst_data", o_data, 0);
        chk("midrst_str", {o_vend, o_hend, o_hstr, o_vstr}, 0);
        chk("midrst_cnt", o_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_stale", o_dvld, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
